// File: rtl/axis_interpolator.sv
// AXI-Stream interpolator: every accepted sample is expanded into cfg_data+1 output
// beats, either repeating the sample (hold) or following it with zeros (zero-stuff).
module axis_interpolator #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 32
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [CNTR_WIDTH-1:0]       cfg_data,
  input  logic                        cfg_mode,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast
);

  localparam logic [CNTR_WIDTH-1:0] CNTR_ONE = CNTR_WIDTH'(1);

  // int_tvalid_reg is the whole FSM: 0 = EMPTY, 1 = BURST.
  logic                        int_tvalid_reg, int_tvalid_next;
  logic [AXIS_TDATA_WIDTH-1:0] data_reg, data_next;
  logic [CNTR_WIDTH-1:0]       cntr_reg, cntr_next;
  logic [CNTR_WIDTH-1:0]       ratio_reg, ratio_next;
  logic                        mode_reg, mode_next;
  logic                        last;
  logic                        in_fire;
  logic                        out_fire;

  // Handshakes: a beat transfers on a rising edge where valid & ready are both high.
  // Valid never waits on ready; a stalled beat holds data/last until it transfers.
  assign last     = (cntr_reg == ratio_reg);
  assign in_fire  = s_axis_tvalid & s_axis_tready;
  assign out_fire = int_tvalid_reg & m_axis_tready;

  always_ff @(posedge aclk) begin
    if (areset) begin
      int_tvalid_reg <= 1'b0;
      data_reg       <= '0;
      cntr_reg       <= '0;
      ratio_reg      <= '0;
      mode_reg       <= 1'b0;
    end else begin
      int_tvalid_reg <= int_tvalid_next;
      data_reg       <= data_next;
      cntr_reg       <= cntr_next;
      ratio_reg      <= ratio_next;
      mode_reg       <= mode_next;
    end
  end

  // A load can only coincide with an output handshake on the last beat, so it wins.
  always_comb begin
    int_tvalid_next = int_tvalid_reg;
    data_next       = data_reg;
    cntr_next       = cntr_reg;
    ratio_next      = ratio_reg;
    mode_next       = mode_reg;
    if (in_fire) begin
      int_tvalid_next = 1'b1;
      data_next       = s_axis_tdata;
      ratio_next      = cfg_data;
      mode_next       = cfg_mode;
      cntr_next       = '0;
    end else if (out_fire) begin
      if (last) begin
        int_tvalid_next = 1'b0;
      end else begin
        cntr_next = cntr_reg + CNTR_ONE;
      end
    end
  end

  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    if (!areset) begin
      s_axis_tready = ~int_tvalid_reg | (m_axis_tready & last);
      m_axis_tvalid = int_tvalid_reg;
      m_axis_tlast  = int_tvalid_reg & last;
      m_axis_tdata  = (~mode_reg | (cntr_reg == '0)) ? data_reg : '0;
    end
  end

endmodule

// File: tb/tb_axis_interpolator.sv
// Bench for axis_interpolator: directed scenarios plus randomized streams checked
// against a beat-list model built from each accepted sample and its configuration.
module tb_axis_interpolator;

  localparam int W  = 16;
  localparam int CW = 4;

  logic          aclk = 1'b0;
  logic          areset;
  logic [CW-1:0] cfg_data;
  logic          cfg_mode;
  logic          s_tready;
  logic [W-1:0]  s_tdata;
  logic          s_tvalid;
  logic          m_tready;
  logic [W-1:0]  m_tdata;
  logic          m_tvalid;
  logic          m_tlast;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit bp_done;

  // Each entry is {tlast, tdata}.
  logic [W:0] exp_q[$];
  logic [W:0] obs_q[$];
  int         obs_t[$];

  axis_interpolator #(.AXIS_TDATA_WIDTH(W), .CNTR_WIDTH(CW)) dut (
    .aclk(aclk), .areset(areset), .cfg_data(cfg_data), .cfg_mode(cfg_mode),
    .s_axis_tready(s_tready), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .m_axis_tready(m_tready), .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast)
  );

  // Clock / cycle counter
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  // Monitor and reference model: an accepted sample becomes cfg_data+1 beats.
  always @(negedge aclk) begin
    if (!areset) begin
      if (m_tvalid && m_tready) begin
        obs_q.push_back({m_tlast, m_tdata});
        obs_t.push_back(cyc);
      end
      if (s_tvalid && s_tready) begin
        for (int k = 0; k <= int'(cfg_data); k++) begin
          exp_q.push_back({(k == int'(cfg_data)), ((cfg_mode && k != 0) ? {W{1'b0}} : s_tdata)});
        end
      end
    end
  end

  // Driver tasks
  task automatic clear_q();
    exp_q.delete();
    obs_q.delete();
    obs_t.delete();
  endtask

  task automatic drive_src(input logic [W-1:0] d, output bit timed_out);
    int n = 0;
    timed_out = 1'b0;
    s_tvalid  = 1'b1;
    s_tdata   = d;
    @(negedge aclk);
    while (!s_tready) begin
      n++;
      if (n > 300) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge aclk);
    end
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic drain(output bit ok);
    m_tready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge aclk);
      #1;
      if (!m_tvalid && !s_tvalid && obs_q.size() == exp_q.size()) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Tests
  task automatic test_reset();
    areset = 1'b1; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;
    cfg_data = '0; cfg_mode = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b exp=0", m_tvalid); end
    checks++; if (m_tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%b exp=0", m_tlast); end
    checks++; if (m_tdata !== '0) begin failures++; $display("FAIL reset_tdata got=%h exp=0", m_tdata); end
    checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL reset_tready got=%b exp=0", s_tready); end
    @(posedge aclk); #1; areset = 1'b0;
    @(negedge aclk);
    checks++; if (s_tready !== 1'b1) begin failures++; $display("FAIL post_reset_tready got=%b exp=1", s_tready); end
    checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL post_reset_tvalid got=%b exp=0", m_tvalid); end
    @(posedge aclk); #1;
  endtask

  task automatic test_hold();
    logic [W:0] e[8];
    bit to, ok;
    for (int i = 0; i < 8; i++) e[i] = {(i == 3 || i == 7), ((i < 4) ? 16'h000A : 16'h000B)};
    clear_q();
    cfg_data = 4'd3; cfg_mode = 1'b0; m_tready = 1'b1;
    drive_src(16'h000A, to);
    checks++; if (to) begin failures++; $display("FAIL hold_accept_a got=timeout exp=accepted"); end
    drive_src(16'h000B, to);
    checks++; if (to) begin failures++; $display("FAIL hold_accept_b got=timeout exp=accepted"); end
    drain(ok);
    checks++; if (!ok || obs_q.size() != 8) begin failures++; $display("FAIL hold_count got=%0d exp=8", obs_q.size()); end
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== e[i]) begin failures++; $display("FAIL hold_beat[%0d] got=%h exp=%h", i, obs_q[i], e[i]); end
      if (i > 0) begin
        checks++; if (obs_t[i] != obs_t[i-1] + 1) begin failures++; $display("FAIL hold_gap[%0d] got=%0d exp=%0d", i, obs_t[i], obs_t[i-1] + 1); end
      end
    end
  endtask

  task automatic test_zero_stuff();
    logic [W:0] e[3];
    bit to, ok;
    e[0] = {1'b0, 16'h0055}; e[1] = {1'b0, 16'h0000}; e[2] = {1'b1, 16'h0000};
    clear_q();
    cfg_data = 4'd2; cfg_mode = 1'b1; m_tready = 1'b1;
    drive_src(16'h0055, to);
    drain(ok);
    checks++; if (to || !ok || obs_q.size() != 3) begin failures++; $display("FAIL zs_count got=%0d exp=3", obs_q.size()); end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== e[i]) begin failures++; $display("FAIL zs_beat[%0d] got=%h exp=%h", i, obs_q[i], e[i]); end
    end
  endtask

  task automatic test_pass_through();
    logic [W-1:0] d[8];
    bit ok;
    clear_q();
    cfg_data = 4'd0; cfg_mode = 1'($urandom_range(0, 1)); m_tready = 1'b1;
    for (int i = 0; i < 8; i++) d[i] = W'($urandom);
    s_tvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_tdata = d[i];
      @(negedge aclk);
      checks++; if (s_tready !== 1'b1) begin failures++; $display("FAIL pt_tready[%0d] got=%b exp=1", i, s_tready); end
      @(posedge aclk); #1;
    end
    s_tvalid = 1'b0;
    drain(ok);
    checks++; if (!ok || obs_q.size() != 8) begin failures++; $display("FAIL pt_count got=%0d exp=8", obs_q.size()); end
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== {1'b1, d[i]}) begin failures++; $display("FAIL pt_beat[%0d] got=%h exp=%h", i, obs_q[i], {1'b1, d[i]}); end
      if (i > 0) begin
        checks++; if (obs_t[i] != obs_t[i-1] + 1) begin failures++; $display("FAIL pt_gap[%0d] got=%0d exp=%0d", i, obs_t[i], obs_t[i-1] + 1); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n_to = 0;
    clear_q();
    cfg_data = 4'd1; bp_done = 1'b0;
    fork
      begin
        bit to;
        for (int i = 0; i < 24; i++) begin
          cfg_mode = 1'($urandom_range(0, 1));
          drive_src(W'($urandom), to);
          if (to) n_to++;
          repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
        end
        bp_done = 1'b1;
      end
      begin
        bit prev_stall = 1'b0;
        logic [W+1:0] prev = '0;
        while (!bp_done) begin
          @(posedge aclk); #1;
          m_tready = 1'($urandom_range(0, 1));
          @(negedge aclk);
          if (prev_stall) begin
            checks++;
            if ({m_tvalid, m_tlast, m_tdata} !== prev) begin
              failures++; $display("FAIL bp_stable got=%h exp=%h", {m_tvalid, m_tlast, m_tdata}, prev);
            end
          end
          prev_stall = m_tvalid && !m_tready;
          prev = {m_tvalid, m_tlast, m_tdata};
        end
      end
    join
    drain(ok);
    checks++; if (n_to != 0 || !ok || obs_q.size() != 48) begin failures++; $display("FAIL bp_count got=%0d exp=48", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_beat[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_cfg_change();
    logic [W-1:0] x, y;
    bit to, ok;
    x = W'($urandom); y = W'($urandom);
    clear_q();
    cfg_data = 4'd4; cfg_mode = 1'b0; m_tready = 1'b1;
    drive_src(x, to);
    cfg_data = 4'd1;
    drive_src(y, to);
    drain(ok);
    checks++; if (!ok || obs_q.size() != 7) begin failures++; $display("FAIL cfg_count got=%0d exp=7", obs_q.size()); end
    for (int i = 0; i < 7 && i < obs_q.size(); i++) begin
      logic [W:0] e;
      e = {(i == 4 || i == 6), ((i < 5) ? x : y)};
      checks++; if (obs_q[i] !== e) begin failures++; $display("FAIL cfg_beat[%0d] got=%h exp=%h", i, obs_q[i], e); end
    end
  endtask

  task automatic test_reset_mid_burst();
    bit to, ok, seen;
    clear_q();
    cfg_data = 4'd7; cfg_mode = 1'b0; m_tready = 1'b1;
    drive_src(16'h0003, to);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (obs_q.size() >= 3) begin seen = 1'b1; break; end
      @(posedge aclk); #1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL rm_three_beats got=%0d exp=3", obs_q.size()); end
    areset = 1'b1;
    @(negedge aclk);
    checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL rm_tvalid got=%b exp=0", m_tvalid); end
    @(posedge aclk); #1; areset = 1'b0;
    clear_q();
    @(negedge aclk);
    checks++; if (s_tready !== 1'b1) begin failures++; $display("FAIL rm_tready got=%b exp=1", s_tready); end
    checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL rm_discard got=%b exp=0", m_tvalid); end
    @(posedge aclk); #1;
    drive_src(16'h0009, to);
    drain(ok);
    checks++; if (!ok || obs_q.size() != 8) begin failures++; $display("FAIL rm_count got=%0d exp=8", obs_q.size()); end
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== {(i == 7), 16'h0009}) begin failures++; $display("FAIL rm_beat[%0d] got=%h exp=%h", i, obs_q[i], {(i == 7), 16'h0009}); end
    end
  endtask

  task automatic test_max_ratio();
    bit to, ok;
    clear_q();
    cfg_data = 4'hF; m_tready = 1'b1;
    for (int s = 0; s < 2; s++) begin
      cfg_mode = 1'($urandom_range(0, 1));
      drive_src(W'($urandom), to);
    end
    drain(ok);
    checks++; if (!ok || obs_q.size() != 32) begin failures++; $display("FAIL max_count got=%0d exp=32", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL max_beat[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_zero_stuff();
    test_pass_through();
    test_backpressure();
    test_cfg_change();
    test_reset_mid_burst();
    test_max_ratio();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
